// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, fetch FSM
// states and the canonical NOP encoding.
package fetch_unit_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h00000013;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with wrapping pointers, synchronous flush and an
// occupancy count. The head reads as zero whenever the FIFO is empty.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && !flush_i && (count_q != '0);
  assign do_push = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential imem requests under a credit
// scheme so responses always fit the instruction buffer, and discards the
// responses that were in flight when the datapath redirects fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]      fetch_pc_q;
  logic [CW-1:0]        discard_q;
  fetch_state_e         state_q;

  logic [CW-1:0]        buf_count, outstanding, discard_load;
  logic [XLEN-1:0]      rsp_pc;
  logic [XLEN+ILEN-1:0] buf_head;
  logic                 req_fire, rsp_stale, buf_push, buf_pop;
  logic                 unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_valid = !reset && !redirect_valid &&
                          ((int'(buf_count) + int'(outstanding)) < DEPTH);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_stale    = redirect_valid || (discard_q != '0);
  assign buf_push     = imem_rsp_valid && !rsp_stale;
  assign buf_pop      = instr_valid && instr_ready && !redirect_valid;
  assign discard_load = outstanding - CW'(imem_rsp_valid);

  assign instr_valid       = !reset && (buf_count != '0);
  assign {pc, instruction} = reset ? '0 : buf_head;

  // The tag queue remembers the PC of every outstanding request so each
  // in-order response can be paired with its address; its occupancy is the
  // outstanding-request count.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tags (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (imem_rsp_valid),
    .flush_i (1'b0),
    .head_o  (rsp_pc),
    .count_o (outstanding)
  );

  fetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (buf_push),
    .data_i  ({rsp_pc, imem_rsp_data}),
    .pop_i   (buf_pop),
    .flush_i (redirect_valid),
    .head_o  (buf_head),
    .count_o (buf_count)
  );

  // Fetch PC, discard counter and RUN/DRAIN state; a redirect reloads all three.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
      state_q    <= RUN;
    end else if (redirect_valid) begin
      fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      discard_q  <= discard_load;
      state_q    <= (discard_load != '0) ? DRAIN : RUN;
    end else begin
      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + 64'd4;
      end
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_q <= discard_q - 1'b1;
      end
      case (state_q)
        DRAIN: begin
          if ((discard_q == '0) || ((discard_q == CW'(1)) && imem_rsp_valid)) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule
